// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM state (request / holding a stalled response / draining a squashed fetch)
//   OP_MSB/OP_LSB : opcode field of the instruction that feeds the Control decoder
//   PC_INC        : sequential PC step in bytes
package fetch_pkg;

   localparam int unsigned ADDR_W_DEF  = 64;
   localparam int unsigned INSTR_W_DEF = 32;
   localparam int unsigned OP_MSB      = 31;
   localparam int unsigned OP_LSB      = 21;
   localparam int unsigned OP_W        = OP_MSB - OP_LSB + 1;
   localparam int unsigned PC_INC      = 4;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load / hold / flush of {valid, pc, instr}.
//   clk, reset  : clock, synchronous active-high reset (clears all fields)
//   load        : capture pc_in/instr_in and mark valid
//   flush       : invalidate (wins over load); pc/instr keep their last values
//   valid/pc_out/instr_out : registered contents
module if_id_reg #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               valid,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [INSTR_W-1:0] instr_out
);

   logic               valid_q, valid_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   // Next contents: flush beats load, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = pc_in;
         instr_d = instr_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid     = valid_q;
   assign pc_out    = pc_q;
   assign instr_out = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// drives the IF/ID register. Handles hazard stalls and branch redirects.
//   imem_req/imem_addr         : fetch request, address stable while req is high
//   imem_rdata/imem_valid      : response, one-cycle strobe
//   stall                      : hold IF/ID (load-use hazard)
//   redirect/redirect_target   : taken branch, flushes IF/ID and restarts fetch
//   if_id_valid/pc/instr/op    : IF/ID contents, op = instr[31:21] to Control
//   pc                         : current fetch PC (debug)
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned      ADDR_W   = ADDR_W_DEF,
   parameter int unsigned      INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               if_id_valid,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [OP_W-1:0]    if_id_op,
   output logic [ADDR_W-1:0]  pc
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
   logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
   logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

   logic               ifid_load, ifid_flush;
   logic [ADDR_W-1:0]  ifid_pc_in;
   logic [INSTR_W-1:0] ifid_instr_in;
   logic [ADDR_W-1:0]  redirect_pc;

   // Branch targets are word aligned; low two bits are forced to zero.
   assign redirect_pc = redirect_target & ~ADDR_W'(2'b11);

   // Next-state and IF/ID control. Redirect has priority over everything, including stall.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      drain_addr_d  = drain_addr_q;
      hold_pc_d     = hold_pc_q;
      hold_instr_d  = hold_instr_q;
      ifid_load     = 1'b0;
      ifid_flush    = 1'b0;
      ifid_pc_in    = pc_q;
      ifid_instr_in = imem_rdata;

      if (redirect) begin
         ifid_flush = 1'b1;
         pc_d       = redirect_pc;
         case (state_q)
            S_REQ: begin
               // A request still in flight must be absorbed before refetching.
               if (!imem_valid) begin
                  state_d      = S_DRAIN;
                  drain_addr_d = pc_q;
               end
            end
            S_HOLD: begin
               state_d      = S_REQ;
               hold_pc_d    = '0;
               hold_instr_d = '0;
            end
            default: ;  // S_DRAIN: keep draining, newest target already in pc_d
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_valid) begin
                  pc_d = pc_q + ADDR_W'(PC_INC);
                  if (stall) begin
                     hold_pc_d    = pc_q;
                     hold_instr_d = imem_rdata;
                     state_d      = S_HOLD;
                  end else begin
                     ifid_load = 1'b1;
                  end
               end else if (!stall) begin
                  ifid_flush = 1'b1;  // wait state: insert a bubble
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  ifid_load     = 1'b1;
                  ifid_pc_in    = hold_pc_q;
                  ifid_instr_in = hold_instr_q;
                  hold_pc_d     = '0;
                  hold_instr_d  = '0;
                  state_d       = S_REQ;
               end
            end
            S_DRAIN: begin
               if (imem_valid) begin
                  state_d = S_REQ;  // squashed data discarded; pc already holds the target
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         hold_pc_q    <= '0;
         hold_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   // Request depends on state only (plus reset, which must drop it in the reset cycle).
   assign imem_req  = !reset && (state_q != S_HOLD);
   assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   assign pc        = pc_q;

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_if_id (
      .clk       (clk),
      .reset     (reset),
      .load      (ifid_load),
      .flush     (ifid_flush),
      .pc_in     (ifid_pc_in),
      .instr_in  (ifid_instr_in),
      .valid     (if_id_valid),
      .pc_out    (if_id_pc),
      .instr_out (if_id_instr)
   );

   assign if_id_op = if_id_instr[OP_MSB:OP_LSB];

endmodule
